japb_ctrl: RTL and testbench

Parametrised APB control/status block for the AXI-Stream JPEG encoder; successor to the single-shot register file. Adds a capture sequencer for multi-frame and continuous capture with abort, latched results, a frame counter, W1C interrupts, PSLVERR on illegal accesses, and config locking while busy. Sits between the host APB bus and the encoder's capture/config inputs.

---
 rtl/japb_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_japb_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/japb_ctrl.sv
// APB control/status block for the streaming JPEG encoder: capture sequencer, W1C interrupts, config locking.
// Optional PERF_CYCLES counter at word 0xD is built only when JAPB_PERF_CNT_EN is defined.
module japb_ctrl #(
  parameter int SENSOR_X_SIZE = 720,
  parameter int SENSOR_Y_SIZE = 720,
  parameter int QF_W          = 2,
  parameter int SIZE_W        = 20,
  parameter int ADDR_W        = 4
) (
  input  logic                             pclk,
  input  logic                             preset,
  output logic                             start_capture,
  output logic [QF_W-1:0]                  qf_select,
  output logic [$clog2(SENSOR_X_SIZE)-1:0] x_size_m1,
  output logic [$clog2(SENSOR_Y_SIZE)-1:0] y_size_m1,
  input  logic                             image_valid,
  input  logic [SIZE_W-1:0]                image_size,
  output logic                             irq,
  input  logic [ADDR_W-1:0]                paddr,
  input  logic                             pwrite,
  input  logic                             psel,
  input  logic                             penable,
  output logic                             pready,
  output logic                             pslverr,
  input  logic [31:0]                      pwdata,
  output logic [31:0]                      prdata
);

  localparam int XW = $clog2(SENSOR_X_SIZE);
  localparam int YW = $clog2(SENSOR_Y_SIZE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(32'h0);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h1);
  localparam logic [ADDR_W-1:0] A_PEND   = ADDR_W'(32'h2);
  localparam logic [ADDR_W-1:0] A_EN     = ADDR_W'(32'h3);
  localparam logic [ADDR_W-1:0] A_QF     = ADDR_W'(32'h6);
  localparam logic [ADDR_W-1:0] A_FC     = ADDR_W'(32'h7);
  localparam logic [ADDR_W-1:0] A_SIZE   = ADDR_W'(32'h9);
  localparam logic [ADDR_W-1:0] A_RDY    = ADDR_W'(32'hA);
  localparam logic [ADDR_W-1:0] A_BYTES  = ADDR_W'(32'hB);
  localparam logic [ADDR_W-1:0] A_DONE   = ADDR_W'(32'hC);
`ifdef JAPB_PERF_CNT_EN
  localparam logic [ADDR_W-1:0] A_PERF   = ADDR_W'(32'hD);
`endif

  logic [1:0]        state_q, state_d;
  logic [1:0]        sync_q;
  logic              ready_q;
  logic [7:0]        remaining_q, remaining_d;
  logic [15:0]       frames_done_q, frames_done_d;
  logic [SIZE_W-1:0] bytes_q, bytes_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        en_q, en_d;
  logic [QF_W-1:0]   qf_q, qf_d;
  logic [7:0]        fc_q, fc_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              start_capture_q;
  logic              irq_q;

  logic        acc_s, busy_s, ready_sync_s, rise_s;
  logic        mapped_s, ro_s, cfg_s, err_s, wr_ok_s;
  logic        start_cmd_s, abort_cmd_s, set_done_s, set_ovf_s;
  logic [31:0] rdata_s;
  logic        unused_s;

`ifdef JAPB_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;
`endif

  assign acc_s        = psel & penable;
  assign busy_s       = (state_q != ST_IDLE);
  assign ready_sync_s = sync_q[1];
  assign rise_s       = ready_sync_s & ~ready_q;
  assign unused_s     = ^pwdata;

  // Address decode and access-error classification
  always_comb begin
    mapped_s = 1'b0;
    ro_s     = 1'b0;
    cfg_s    = 1'b0;
    case (paddr)
      A_CMD:    mapped_s = 1'b1;
      A_STATUS: begin mapped_s = 1'b1; ro_s = 1'b1; end
      A_PEND:   mapped_s = 1'b1;
      A_EN:     mapped_s = 1'b1;
      A_QF:     begin mapped_s = 1'b1; cfg_s = 1'b1; end
      A_FC:     begin mapped_s = 1'b1; cfg_s = 1'b1; end
      A_SIZE:   begin mapped_s = 1'b1; cfg_s = 1'b1; end
      A_RDY:    begin mapped_s = 1'b1; ro_s = 1'b1; end
      A_BYTES:  begin mapped_s = 1'b1; ro_s = 1'b1; end
      A_DONE:   begin mapped_s = 1'b1; ro_s = 1'b1; end
`ifdef JAPB_PERF_CNT_EN
      A_PERF:   begin mapped_s = 1'b1; ro_s = 1'b1; end
`endif
      default:  mapped_s = 1'b0;
    endcase
    if (acc_s) begin
      err_s = ~mapped_s
            | (pwrite & (ro_s | (cfg_s & busy_s) | ((paddr == A_CMD) & pwdata[0] & busy_s)));
    end else begin
      err_s = 1'b0;
    end
    wr_ok_s     = acc_s & pwrite & ~err_s;
    start_cmd_s = wr_ok_s & (paddr == A_CMD) & pwdata[0];
    abort_cmd_s = wr_ok_s & (paddr == A_CMD) & pwdata[1];
  end

  // Combinational read mux, zero outside a selected transfer
  always_comb begin
    rdata_s = 32'h0;
    if (psel) begin
      case (paddr)
        A_STATUS: rdata_s[1:0] = {ready_sync_s, busy_s};
        A_PEND:   rdata_s[1:0] = pend_q;
        A_EN:     rdata_s[1:0] = en_q;
        A_QF:     rdata_s[QF_W-1:0] = qf_q;
        A_FC:     rdata_s[7:0] = fc_q;
        A_SIZE:   begin rdata_s[XW-1:0] = x_q; rdata_s[16 +: YW] = y_q; end
        A_RDY:    rdata_s[0] = ready_sync_s;
        A_BYTES:  rdata_s[SIZE_W-1:0] = bytes_q;
        A_DONE:   rdata_s[15:0] = frames_done_q;
`ifdef JAPB_PERF_CNT_EN
        A_PERF:   rdata_s = perf_q;
`endif
        default:  rdata_s = 32'h0;
      endcase
    end else begin
      rdata_s = 32'h0;
    end
  end

  // Capture sequencer; ABORT overrides START and frame completion
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    frames_done_d = frames_done_q;
    bytes_d       = bytes_q;
    set_done_s    = 1'b0;
    set_ovf_s     = 1'b0;
    if (abort_cmd_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          set_ovf_s = rise_s;
          if (start_cmd_s) begin
            state_d       = ST_ARM;
            remaining_d   = fc_q;
            frames_done_d = 16'h0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARM: begin
          set_ovf_s = rise_s;
          state_d   = ST_BUSY;
        end
        ST_BUSY: begin
          if (rise_s) begin
            bytes_d       = image_size;
            frames_done_d = frames_done_q + 16'd1;
            set_done_s    = 1'b1;
            if ((fc_q == 8'd0) || (remaining_q > 8'd1)) begin
              remaining_d = remaining_q - 8'd1;
              state_d     = ST_ARM;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_BUSY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Register-file next state; hardware pend set wins over a same-cycle W1C
  always_comb begin
    en_d = en_q;
    qf_d = qf_q;
    fc_d = fc_q;
    x_d  = x_q;
    y_d  = y_q;
    if (wr_ok_s && (paddr == A_PEND)) begin
      pend_d = pend_q & ~pwdata[1:0];
    end else begin
      pend_d = pend_q;
    end
    pend_d = pend_d | {set_ovf_s, set_done_s};
    if (wr_ok_s) begin
      case (paddr)
        A_EN:    en_d = pwdata[1:0];
        A_QF:    qf_d = pwdata[QF_W-1:0];
        A_FC:    fc_d = pwdata[7:0];
        A_SIZE:  begin x_d = pwdata[XW-1:0]; y_d = pwdata[16 +: YW]; end
        default: en_d = en_q;
      endcase
    end else begin
      en_d = en_q;
    end
  end

`ifdef JAPB_PERF_CNT_EN
  // Cycle counter: cleared on ARM entry, runs in BUSY, frozen by completion or abort
  always_comb begin
    if ((state_d == ST_ARM) && (state_q != ST_ARM)) begin
      perf_d = 32'h0;
    end else if ((state_q == ST_BUSY) && !rise_s && !abort_cmd_s) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Performance counter register
  always_ff @(posedge pclk) begin
    if (preset) begin
      perf_q <= 32'h0;
    end else begin
      perf_q <= perf_d;
    end
  end
`endif

  // State, configuration and synchroniser registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q         <= ST_IDLE;
      sync_q          <= 2'b00;
      ready_q         <= 1'b0;
      remaining_q     <= 8'h0;
      frames_done_q   <= 16'h0;
      bytes_q         <= '0;
      pend_q          <= 2'b00;
      en_q            <= 2'b00;
      qf_q            <= '0;
      fc_q            <= 8'd1;
      x_q             <= XW'(SENSOR_X_SIZE - 1);
      y_q             <= YW'(SENSOR_Y_SIZE - 1);
      start_capture_q <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync_q          <= {sync_q[0], image_valid};
      ready_q         <= ready_sync_s;
      remaining_q     <= remaining_d;
      frames_done_q   <= frames_done_d;
      bytes_q         <= bytes_d;
      pend_q          <= pend_d;
      en_q            <= en_d;
      qf_q            <= qf_d;
      fc_q            <= fc_d;
      x_q             <= x_d;
      y_q             <= y_d;
      start_capture_q <= (state_d == ST_ARM);
      irq_q           <= |(pend_q & en_q);
    end
  end

  assign start_capture = start_capture_q;
  assign irq           = irq_q;
  assign qf_select     = qf_q;
  assign x_size_m1     = x_q;
  assign y_size_m1     = y_q;
  assign pready        = 1'b1;
  assign pslverr       = err_s;
  assign prdata        = rdata_s;

endmodule

// File: tb/tb_japb_ctrl.sv
// Directed self-checking bench for japb_ctrl (default build, PERF counter disabled unless JAPB_PERF_CNT_EN).
module tb_japb_ctrl;

  logic        pclk = 1'b0;
  logic        preset;
  logic        start_capture;
  logic [1:0]  qf_select;
  logic [9:0]  x_size_m1;
  logic [9:0]  y_size_m1;
  logic        image_valid;
  logic [19:0] image_size;
  logic        irq;
  logic [3:0]  paddr;
  logic        pwrite, psel, penable;
  logic        pready, pslverr;
  logic [31:0] pwdata, prdata;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int p0;

  japb_ctrl dut (
    .pclk(pclk), .preset(preset), .start_capture(start_capture),
    .qf_select(qf_select), .x_size_m1(x_size_m1), .y_size_m1(y_size_m1),
    .image_valid(image_valid), .image_size(image_size), .irq(irq),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pready(pready), .pslverr(pslverr), .pwdata(pwdata), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) if (start_capture === 1'b1) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_wr(input string tag, input logic [3:0] a, input logic [31:0] d, input logic exp_err);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    #3 chk({tag, "_err"}, {31'b0, pslverr}, {31'b0, exp_err});
    chk({tag, "_rdy"}, {31'b0, pready}, 32'h1);
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input string tag, input logic [3:0] a, input logic [31:0] exp, input logic exp_err);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    #3 chk(tag, prdata, exp);
    chk({tag, "_err"}, {31'b0, pslverr}, {31'b0, exp_err});
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic frame(input logic [19:0] sz);
    image_size = sz; image_valid = 1'b1;
    cyc(4);
    image_valid = 1'b0;
    cyc(3);
  endtask

  initial begin
    preset = 1'b1; image_valid = 1'b0; image_size = 20'h0;
    paddr = 4'h0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0; pwdata = 32'h0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    // 1. reset values
    chk("rst_sc", {31'b0, start_capture}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_err", {31'b0, pslverr}, 32'h0);
    chk("rst_prdata_idle", prdata, 32'h0);
    chk("rst_x", {22'b0, x_size_m1}, 32'd719);
    chk("rst_y", {22'b0, y_size_m1}, 32'd719);
    apb_rd("rst_size", 4'h9, 32'h02CF02CF, 1'b0);
    apb_rd("rst_qf", 4'h6, 32'h0, 1'b0);
    apb_rd("rst_fc", 4'h7, 32'h1, 1'b0);
    apb_rd("rst_status", 4'h1, 32'h0, 1'b0);
    apb_rd("rst_done", 4'hC, 32'h0, 1'b0);
    apb_rd("rst_cmd_rd", 4'h0, 32'h0, 1'b0);
    chk("rst_pulses", pulses, 0);

    // 2. single frame with interrupt
    apb_wr("en_wr", 4'h3, 32'h1, 1'b0);
    apb_wr("start1", 4'h0, 32'h1, 1'b0);
    chk("sc_t1", {31'b0, start_capture}, 32'h1);
    cyc(1);
    chk("sc_t2", {31'b0, start_capture}, 32'h0);
    apb_rd("status_busy", 4'h1, 32'h1, 1'b0);
    cyc(12);
    frame(20'h01234);
    apb_rd("bytes1", 4'hB, 32'h1234, 1'b0);
    apb_rd("done1", 4'hC, 32'h1, 1'b0);
    apb_rd("pend1", 4'h2, 32'h1, 1'b0);
    chk("irq1", {31'b0, irq}, 32'h1);
    apb_rd("status_idle", 4'h1, 32'h0, 1'b0);
    chk("pulses1", pulses, 1);
    apb_wr("pend_clr", 4'h2, 32'h1, 1'b0);
    chk("irq_hold", {31'b0, irq}, 32'h1);
    cyc(1);
    chk("irq_clr", {31'b0, irq}, 32'h0);
`ifndef JAPB_PERF_CNT_EN
    apb_rd("perf_unmapped", 4'hD, 32'h0, 1'b1);
`endif

    // 3. three-frame capture
    apb_wr("fc3", 4'h7, 32'h3, 1'b0);
    p0 = pulses;
    apb_wr("start3", 4'h0, 32'h1, 1'b0);
    frame(20'h11111);
    frame(20'h22222);
    frame(20'hABCDE);
    cyc(5);
    chk("pulses3", pulses - p0, 3);
    apb_rd("done3", 4'hC, 32'h3, 1'b0);
    apb_rd("bytes3", 4'hB, 32'hABCDE, 1'b0);
    apb_rd("status3", 4'h1, 32'h0, 1'b0);

    // 4. illegal accesses while busy
    p0 = pulses;
    apb_wr("start4", 4'h0, 32'h1, 1'b0);
    apb_wr("size_busy", 4'h9, 32'h00100010, 1'b1);
    apb_rd("size_keep", 4'h9, 32'h02CF02CF, 1'b0);
    apb_wr("qf_busy", 4'h6, 32'h1, 1'b1);
    apb_rd("qf_keep", 4'h6, 32'h0, 1'b0);
    apb_wr("fc_busy", 4'h7, 32'h5, 1'b1);
    apb_wr("start_busy", 4'h0, 32'h1, 1'b1);
    apb_wr("ro_bytes", 4'hB, 32'h1, 1'b1);
    apb_wr("ro_status", 4'h1, 32'h1, 1'b1);
    apb_rd("unmapped_e", 4'hE, 32'h0, 1'b1);
    apb_wr("abort4", 4'h0, 32'h2, 1'b0);
    apb_rd("status4", 4'h1, 32'h0, 1'b0);
    chk("pulses4", pulses - p0, 1);
    apb_rd("fc_keep", 4'h7, 32'h3, 1'b0);

    // 5. continuous capture with abort, then idle overflow
    apb_wr("pend_clr5", 4'h2, 32'h3, 1'b0);
    apb_wr("fc0", 4'h7, 32'h0, 1'b0);
    p0 = pulses;
    apb_wr("start5", 4'h0, 32'h1, 1'b0);
    frame(20'h00777);
    frame(20'h00888);
    apb_rd("done5", 4'hC, 32'h2, 1'b0);
    apb_rd("status5_busy", 4'h1, 32'h1, 1'b0);
    apb_wr("abort5", 4'h0, 32'h2, 1'b0);
    apb_rd("status5_idle", 4'h1, 32'h0, 1'b0);
    cyc(10);
    chk("pulses5", pulses - p0, 3);
    apb_wr("pend_clr5b", 4'h2, 32'h3, 1'b0);
    frame(20'h00055);
    apb_rd("pend_ovf5", 4'h2, 32'h2, 1'b0);
    apb_rd("bytes5", 4'hB, 32'h888, 1'b0);
    apb_wr("qf_wr", 4'h6, 32'hFF, 1'b0);
    apb_rd("qf_rd", 4'h6, 32'h3, 1'b0);
    chk("qf_port", {30'b0, qf_select}, 32'h3);
    apb_wr("size_wr", 4'h9, 32'h01DF027F, 1'b0);
    chk("x_port", {22'b0, x_size_m1}, 32'h27F);
    chk("y_port", {22'b0, y_size_m1}, 32'h1DF);

    // 6. reset mid-BUSY
    apb_wr("pend_clr6", 4'h2, 32'h3, 1'b0);
    apb_wr("fc2", 4'h7, 32'h2, 1'b0);
    apb_wr("start6", 4'h0, 32'h1, 1'b0);
    frame(20'h00099);
    apb_rd("done6", 4'hC, 32'h1, 1'b0);
    apb_rd("status6", 4'h1, 32'h1, 1'b0);
    chk("irq6", {31'b0, irq}, 32'h1);
    preset = 1'b1;
    cyc(1);
    preset = 1'b0;
    chk("r6_sc", {31'b0, start_capture}, 32'h0);
    chk("r6_irq", {31'b0, irq}, 32'h0);
    chk("r6_qf", {30'b0, qf_select}, 32'h0);
    chk("r6_x", {22'b0, x_size_m1}, 32'd719);
    apb_rd("r6_size", 4'h9, 32'h02CF02CF, 1'b0);
    apb_rd("r6_fc", 4'h7, 32'h1, 1'b0);
    apb_rd("r6_done", 4'hC, 32'h0, 1'b0);
    apb_rd("r6_pend", 4'h2, 32'h0, 1'b0);
    apb_rd("r6_en", 4'h3, 32'h0, 1'b0);
    apb_rd("r6_bytes", 4'hB, 32'h0, 1'b0);
    apb_rd("r6_status", 4'h1, 32'h0, 1'b0);
    p0 = pulses;
    frame(20'h00042);
    apb_rd("r6_pend_ovf", 4'h2, 32'h2, 1'b0);
    apb_rd("r6_done_after", 4'hC, 32'h0, 1'b0);
    apb_rd("r6_bytes_after", 4'hB, 32'h0, 1'b0);
    cyc(2);
    chk("r6_pulses", pulses - p0, 0);
    chk("r6_irq_after", {31'b0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
